// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised synchronous FIFO with occupancy flags; define SYNC_FIFO_FWFT_EN for first-word-fall-through
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    buf_empty,
    output logic                    buf_full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  counter,
    output logic                    overflow,
    output logic                    underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  rd_acc, wr_acc;

    // flags decode from the registered count; a full FIFO still takes a write when a read frees a slot
    always_comb begin
        buf_empty    = counter == '0;
        buf_full     = counter == FULL_LVL;
        almost_empty = counter <= AE_LVL;
        almost_full  = counter >= AF_LVL;
        rd_acc       = rd_en && !buf_empty;
        wr_acc       = wr_en && (!buf_full || rd_acc);
    end

    // storage write; reset and flush leave contents alone but block new writes
    always_ff @(posedge clk)
        if (rst && !clr && wr_acc) mem[wr_ptr] <= data_in;

    // pointers, occupancy and sticky error flags; flush overrides any request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            counter   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            counter   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_acc ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr    <= rd_acc ? rd_ptr + AW'(1) : rd_ptr;
            counter   <= counter + CW'(wr_acc) - CW'(rd_acc);
            overflow  <= overflow || (wr_en && buf_full && !rd_en);
            underflow <= underflow || (rd_en && buf_empty);
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // head entry is visible as soon as it is present
    always_comb data_out = buf_empty ? '0 : mem[rd_ptr];
`else
    // registered read port: loads the head on an accepted read, holds otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        data_out <= '0;
        else if (clr)    data_out <= '0;
        else if (rd_acc) data_out <= mem[rd_ptr];
    end
`endif
endmodule
